// File: rtl/mem_stage_ctl.sv
// Memory-stage controller: sequences one pipeline load/store at a time through
// the cache memory system, reports a one-cycle response, keeps hit/miss
// statistics and latches a sticky fault on protocol errors or timeout.
module mem_stage_ctl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p_rd,
    input  logic        p_wr,
    input  logic [15:0] p_addr,
    input  logic [15:0] p_wdata,
    output logic        p_busy,
    output logic        resp_valid,
    output logic [15:0] resp_data,
    output logic        resp_align_err,
    output logic [15:0] m_Addr,
    output logic [15:0] m_DataIn,
    output logic        m_Rd,
    output logic        m_Wr,
    input  logic [15:0] m_DataOut,
    input  logic        m_Done,
    input  logic        m_Stall,
    input  logic        m_CacheHit,
    input  logic        m_err,
    output logic        fault,
    output logic [15:0] hit_cnt,
    output logic [15:0] miss_cnt
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state_q, state_d;
    logic             op_wr_q, op_wr_d;
    logic [15:0]      m_addr_q, m_addr_d;
    logic [15:0]      m_data_in_q, m_data_in_d;
    logic             m_rd_q, m_rd_d;
    logic             m_wr_q, m_wr_d;
    logic             resp_valid_q, resp_valid_d;
    logic [15:0]      resp_data_q, resp_data_d;
    logic             align_err_q, align_err_d;
    logic             fault_q, fault_d;
    logic             p_busy_q, p_busy_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [CNT_W-1:0] tmo_q, tmo_d;

    // m_Stall carries no sequencing meaning for this controller
    logic stall_unused;
    assign stall_unused = m_Stall;

    // Next state, datapath captures and registered output values
    always_comb begin
        state_d     = state_q;
        op_wr_d     = op_wr_q;
        m_addr_d    = m_addr_q;
        m_data_in_d = m_data_in_q;
        resp_data_d = resp_data_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        tmo_d       = tmo_q;
        align_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (p_rd && p_wr) begin
                    state_d = S_ERR;
                end else if (p_rd ^ p_wr) begin
                    if (p_addr[0]) begin
                        align_err_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        m_addr_d    = p_addr;
                        m_data_in_d = p_wdata;
                        op_wr_d     = p_wr;
                        state_d     = S_ISSUE;
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (m_Done) begin
                    if (!op_wr_q) resp_data_d = m_DataOut;
                    if (m_CacheHit) begin
                        if (hit_cnt_q != CNT_MAX) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    end else begin
                        if (miss_cnt_q != CNT_MAX) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    end
                    tmo_d   = '0;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + CNT_W'(1);
                    if (tmo_q == TMO_LAST) state_d = S_ERR;
                end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase

        // A completion before the request was even issued is a protocol violation
        if (m_Done && (state_q == S_IDLE || state_q == S_ISSUE)) state_d = S_ERR;
        if (m_err && state_q != S_ERR) state_d = S_ERR;

        // Output strobes follow the state being entered so they line up with it
        m_rd_d       = (state_d == S_ISSUE) && !op_wr_d;
        m_wr_d       = (state_d == S_ISSUE) && op_wr_d;
        resp_valid_d = (state_d == S_DONE);
        align_err_d  = align_err_d && (state_d == S_DONE);
        p_busy_d     = (state_d != S_IDLE);
        fault_d      = (state_d == S_ERR);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_wr_q      <= 1'b0;
            m_addr_q     <= '0;
            m_data_in_q  <= '0;
            m_rd_q       <= 1'b0;
            m_wr_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
            align_err_q  <= 1'b0;
            fault_q      <= 1'b0;
            p_busy_q     <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            tmo_q        <= '0;
        end else begin
            state_q      <= state_d;
            op_wr_q      <= op_wr_d;
            m_addr_q     <= m_addr_d;
            m_data_in_q  <= m_data_in_d;
            m_rd_q       <= m_rd_d;
            m_wr_q       <= m_wr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            align_err_q  <= align_err_d;
            fault_q      <= fault_d;
            p_busy_q     <= p_busy_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
            tmo_q        <= tmo_d;
        end
    end

    assign p_busy         = p_busy_q;
    assign resp_valid     = resp_valid_q;
    assign resp_data      = resp_data_q;
    assign resp_align_err = align_err_q;
    assign m_Addr         = m_addr_q;
    assign m_DataIn       = m_data_in_q;
    assign m_Rd           = m_rd_q;
    assign m_Wr           = m_wr_q;
    assign fault          = fault_q;
    assign hit_cnt        = hit_cnt_q;
    assign miss_cnt       = miss_cnt_q;

endmodule

// File: tb/tb_mem_stage_ctl.sv
// Directed bench for mem_stage_ctl: default-timeout instance for function and
// statistics, TIMEOUT=8 instance sharing the same inputs for the timeout case.
module tb_mem_stage_ctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, p_rd, p_wr;
    logic [15:0] p_addr, p_wdata, m_DataOut;
    logic        m_Done, m_Stall, m_CacheHit, m_err;

    logic        p_busy, resp_valid, resp_align_err, m_Rd, m_Wr, fault;
    logic [15:0] resp_data, m_Addr, m_DataIn, hit_cnt, miss_cnt;

    logic        p_busy8, resp_valid8, resp_align_err8, m_Rd8, m_Wr8, fault8;
    logic [15:0] resp_data8, m_Addr8, m_DataIn8, hit_cnt8, miss_cnt8;

    int n_checks = 0;
    int n_errors = 0;
    int wr_pulses;

    mem_stage_ctl dut (
        .clk(clk), .rst(rst), .p_rd(p_rd), .p_wr(p_wr), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_busy(p_busy), .resp_valid(resp_valid), .resp_data(resp_data),
        .resp_align_err(resp_align_err), .m_Addr(m_Addr), .m_DataIn(m_DataIn),
        .m_Rd(m_Rd), .m_Wr(m_Wr), .m_DataOut(m_DataOut), .m_Done(m_Done),
        .m_Stall(m_Stall), .m_CacheHit(m_CacheHit), .m_err(m_err), .fault(fault),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    mem_stage_ctl #(.TIMEOUT(8)) dut8 (
        .clk(clk), .rst(rst), .p_rd(p_rd), .p_wr(p_wr), .p_addr(p_addr), .p_wdata(p_wdata),
        .p_busy(p_busy8), .resp_valid(resp_valid8), .resp_data(resp_data8),
        .resp_align_err(resp_align_err8), .m_Addr(m_Addr8), .m_DataIn(m_DataIn8),
        .m_Rd(m_Rd8), .m_Wr(m_Wr8), .m_DataOut(m_DataOut), .m_Done(m_Done),
        .m_Stall(m_Stall), .m_CacheHit(m_CacheHit), .m_err(m_err), .fault(fault8),
        .hit_cnt(hit_cnt8), .miss_cnt(miss_cnt8)
    );

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reset_all();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // One aligned read that completes as a cache hit in its first WAIT cycle
    task automatic do_hit(input logic [15:0] addr, input logic [15:0] data);
        p_rd = 1'b1; p_addr = addr;
        tick();                                   // ISSUE
        p_rd = 1'b0;
        tick();                                   // WAIT
        m_Done = 1'b1; m_CacheHit = 1'b1; m_DataOut = data;
        tick();                                   // DONE
        m_Done = 1'b0; m_CacheHit = 1'b0;
        tick();                                   // IDLE
    endtask

    initial begin
        rst = 1'b1; p_rd = 1'b0; p_wr = 1'b0; p_addr = '0; p_wdata = '0;
        m_DataOut = '0; m_Done = 1'b0; m_Stall = 1'b0; m_CacheHit = 1'b0; m_err = 1'b0;
        @(negedge clk);
        tick();
        tick();

        // Reset state
        check_eq("rst_busy",  16'(p_busy), 16'd0);
        check_eq("rst_valid", 16'(resp_valid), 16'd0);
        check_eq("rst_fault", 16'(fault), 16'd0);
        check_eq("rst_rd",    16'(m_Rd), 16'd0);
        check_eq("rst_addr",  m_Addr, 16'h0000);
        check_eq("rst_hits",  hit_cnt, 16'd0);
        rst = 1'b0;
        tick();
        check_eq("idle_busy", 16'(p_busy), 16'd0);

        // Read hit at 0x0040: ISSUE at T+1, m_Done at T+2, response at T+3
        p_rd = 1'b1; p_addr = 16'h0040;
        tick();
        p_rd = 1'b0;
        check_eq("rd_issue_mrd",  16'(m_Rd), 16'd1);
        check_eq("rd_issue_mwr",  16'(m_Wr), 16'd0);
        check_eq("rd_issue_addr", m_Addr, 16'h0040);
        check_eq("rd_issue_busy", 16'(p_busy), 16'd1);
        tick();
        check_eq("rd_wait_mrd",   16'(m_Rd), 16'd0);
        check_eq("rd_wait_valid", 16'(resp_valid), 16'd0);
        m_Done = 1'b1; m_CacheHit = 1'b1; m_DataOut = 16'hBEEF;
        tick();
        m_Done = 1'b0; m_CacheHit = 1'b0; m_DataOut = 16'h0000;
        check_eq("rd_valid", 16'(resp_valid), 16'd1);
        check_eq("rd_data",  resp_data, 16'hBEEF);
        check_eq("rd_hits",  hit_cnt, 16'd1);
        check_eq("rd_miss",  miss_cnt, 16'd0);
        check_eq("rd_aerr",  16'(resp_align_err), 16'd0);
        tick();
        check_eq("rd_pulse_end", 16'(resp_valid), 16'd0);
        check_eq("rd_idle_busy", 16'(p_busy), 16'd0);

        // Write miss at 0x1008, m_Done in the 12th WAIT cycle; the TIMEOUT=8 copy faults
        p_wr = 1'b1; p_addr = 16'h1008; p_wdata = 16'h1234;
        tick();
        p_wr = 1'b0; p_addr = 16'h0000; p_wdata = 16'h0000;
        wr_pulses = 0;
        if (m_Wr) wr_pulses++;
        check_eq("wr_issue_mwr",  16'(m_Wr), 16'd1);
        check_eq("wr_issue_mrd",  16'(m_Rd), 16'd0);
        check_eq("wr_issue_data", m_DataIn, 16'h1234);
        tick();
        for (int w = 1; w <= 11; w++) begin
            if (m_Wr) wr_pulses++;
            check_eq("wr_hold_addr", m_Addr, 16'h1008);
            check_eq("wr_hold_data", m_DataIn, 16'h1234);
            check_eq("tmo8_fault", 16'(fault8), (w >= 9) ? 16'd1 : 16'd0);
            check_eq("tmo8_busy",  16'(p_busy8), 16'd1);
            tick();
        end
        if (m_Wr) wr_pulses++;
        check_eq("wr_done_addr", m_Addr, 16'h1008);
        m_Done = 1'b1; m_CacheHit = 1'b0; m_DataOut = 16'h5555;
        tick();
        m_Done = 1'b0; m_DataOut = 16'h0000;
        check_eq("wr_pulses", 16'(wr_pulses), 16'd1);
        check_eq("wr_valid",  16'(resp_valid), 16'd1);
        check_eq("wr_keep_data", resp_data, 16'hBEEF);
        check_eq("wr_miss",   miss_cnt, 16'd1);
        check_eq("wr_hits",   hit_cnt, 16'd1);
        tick();
        check_eq("wr_idle_busy", 16'(p_busy), 16'd0);
        check_eq("tmo8_sticky",  16'(fault8), 16'd1);
        check_eq("tmo8_busy_stuck", 16'(p_busy8), 16'd1);
        check_eq("tmo8_no_valid", 16'(resp_valid8), 16'd0);

        // Unaligned read: immediate response with alignment error, no access
        p_rd = 1'b1; p_addr = 16'h0003;
        tick();
        p_rd = 1'b0;
        check_eq("ua_mrd",   16'(m_Rd), 16'd0);
        check_eq("ua_valid", 16'(resp_valid), 16'd1);
        check_eq("ua_aerr",  16'(resp_align_err), 16'd1);
        check_eq("ua_hits",  hit_cnt, 16'd1);
        check_eq("ua_miss",  miss_cnt, 16'd1);
        tick();
        check_eq("ua_valid_end", 16'(resp_valid), 16'd0);
        check_eq("ua_aerr_end",  16'(resp_align_err), 16'd0);
        check_eq("ua_busy_end",  16'(p_busy), 16'd0);

        // Reset recovers the faulted instance and clears all statistics
        reset_all();
        check_eq("tmo8_rst_fault", 16'(fault8), 16'd0);
        check_eq("tmo8_rst_busy",  16'(p_busy8), 16'd0);
        check_eq("rst2_hits", hit_cnt, 16'd0);
        check_eq("rst2_miss", miss_cnt, 16'd0);

        // Hit counter saturation from a forced starting value
        force dut.hit_cnt_d = 16'hFFFC;
        tick();
        release dut.hit_cnt_d;
        check_eq("sat_preload", hit_cnt, 16'hFFFC);
        do_hit(16'h0010, 16'h0001);
        do_hit(16'h0012, 16'h0002);
        check_eq("sat_fffe", hit_cnt, 16'hFFFE);
        do_hit(16'h0014, 16'h0003);
        do_hit(16'h0016, 16'h0004);
        do_hit(16'h0018, 16'h0005);
        check_eq("sat_ffff", hit_cnt, 16'hFFFF);
        check_eq("sat_miss", miss_cnt, 16'd0);
        check_eq("sat_last_data", resp_data, 16'h0005);

        // Simultaneous load and store request is fatal until reset
        reset_all();
        p_rd = 1'b1; p_wr = 1'b1; p_addr = 16'h0020;
        tick();
        p_rd = 1'b0; p_wr = 1'b0;
        check_eq("both_fault", 16'(fault), 16'd1);
        check_eq("both_busy",  16'(p_busy), 16'd1);
        check_eq("both_mrd",   16'(m_Rd), 16'd0);
        tick();
        tick();
        check_eq("both_sticky", 16'(fault), 16'd1);
        reset_all();
        check_eq("both_rst_fault", 16'(fault), 16'd0);

        // m_err pulse during WAIT
        p_rd = 1'b1; p_addr = 16'h0020;
        tick();
        p_rd = 1'b0;
        tick();
        m_err = 1'b1;
        tick();
        m_err = 1'b0;
        check_eq("merr_fault", 16'(fault), 16'd1);
        check_eq("merr_valid", 16'(resp_valid), 16'd0);
        reset_all();

        // m_Done while in ISSUE is a protocol violation
        p_rd = 1'b1; p_addr = 16'h0030;
        tick();
        p_rd = 1'b0;
        m_Done = 1'b1; m_CacheHit = 1'b1;
        tick();
        m_Done = 1'b0; m_CacheHit = 1'b0;
        check_eq("early_done_fault", 16'(fault), 16'd1);
        check_eq("early_done_hits",  hit_cnt, 16'd0);
        reset_all();

        // Reset mid-WAIT aborts without a response
        p_wr = 1'b1; p_addr = 16'h0044; p_wdata = 16'hAAAA;
        tick();
        p_wr = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("abort_busy",  16'(p_busy), 16'd0);
        check_eq("abort_valid", 16'(resp_valid), 16'd0);
        check_eq("abort_addr",  m_Addr, 16'h0000);
        m_Done = 1'b1;
        tick();
        m_Done = 1'b0;
        check_eq("abort_no_resp", 16'(resp_valid), 16'd0);
        check_eq("abort_miss",    miss_cnt, 16'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
